uart_alu_ctrl: RTL and testbench

Sequencer between the UART receiver/transmitter and the combinational ALU in the PC-linked top level. It collects three bytes from the UART RX (operand A, operand B, opcode), checks the opcode, and presents A/B/op to the ALU. It then captures the result and hands it to the UART TX with a start pulse, and waits for TX completion before accepting the next frame. An inter-byte timeout recovers from partial frames.

---
 rtl/uart_alu_ctrl_pkg.sv | 16 +
 rtl/uart_alu_ctrl_if.sv | 25 ++
 rtl/uart_alu_ctrl_frame_timeout_counter.sv | 18 +
 rtl/uart_alu_ctrl.sv | 112 +++++++++++
 tb/tb_uart_alu_ctrl.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/uart_alu_ctrl_pkg.sv
// alu_pkg: opcode encodings, FSM state type and opcode check shared by the ALU sequencer.
package alu_pkg;
  localparam int NB_OP = 6;
  localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OP-1:0] OP_NOR = 6'b100111;
  localparam logic [NB_OP-1:0] OP_SRA = 6'b000011;
  localparam logic [NB_OP-1:0] OP_SRL = 6'b000010;
  typedef enum logic [2:0] {ST_WAIT_A, ST_WAIT_B, ST_WAIT_OP, ST_EXEC, ST_WAIT_TX} state_e;
  function automatic logic op_valid(input logic [NB_OP-1:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL};
  endfunction
endpackage

// File: rtl/uart_alu_ctrl_if.sv
// uart_alu_ctrl_if: UART RX/TX and ALU signals seen by the sequencer (master) and its environment (slave).
interface uart_alu_ctrl_if #(parameter int NB_DATA = 8) ();
  import alu_pkg::*;
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_valid;
  logic [NB_DATA-1:0] i_alu_result;
  logic               i_tx_done;
  logic [NB_DATA-1:0] o_alu_a;
  logic [NB_DATA-1:0] o_alu_b;
  logic [NB_OP-1:0]   o_alu_op;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_tx_start;
  logic               o_ready;
  logic               o_op_err;
  logic               o_timeout;
  logic               o_overrun;
  modport master (
    input  i_rx_data, i_rx_valid, i_alu_result, i_tx_done,
    output o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_ready, o_op_err, o_timeout, o_overrun
  );
  modport slave (
    output i_rx_data, i_rx_valid, i_alu_result, i_tx_done,
    input  o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_ready, o_op_err, o_timeout, o_overrun
  );
endinterface

// File: rtl/uart_alu_ctrl_frame_timeout_counter.sv
// frame_timeout_counter: counts idle cycles inside a frame, flags expiry at TIMEOUT_CYCLES-1.
module frame_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);
  localparam int NB_CNT = $clog2(TIMEOUT_CYCLES);
  logic [NB_CNT-1:0] cnt_q;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) cnt_q <= '0;
    else if (i_clear) cnt_q <= '0;
    else if (i_enable) cnt_q <= cnt_q + 1'b1;
  assign o_expire = i_enable && (cnt_q == NB_CNT'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: collects A/B/opcode bytes from UART RX, drives the ALU and hands the result to UART TX.
module uart_alu_ctrl
  import alu_pkg::*;
#(
  parameter int NB_DATA        = 8,
  parameter int F_CLOCK        = 100000000,
  parameter int TIMEOUT_CYCLES = F_CLOCK / 100
) (
  input logic             i_clk,
  input logic             i_reset,
  uart_alu_ctrl_if.master bus
);
  state_e             state_q, state_d;
  logic [NB_DATA-1:0] a_q, a_d, b_q, b_d, tx_q, tx_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic               start_q, start_d, err_q, err_d, to_q, to_d, ovr_q, ovr_d, settle_q, settle_d;
  logic               waiting, expire, clr;
  assign waiting = state_q inside {ST_WAIT_B, ST_WAIT_OP};
  assign clr     = !waiting || bus.i_rx_valid || expire;
  frame_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (clr),
    .i_enable(waiting),
    .o_expire(expire)
  );
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    tx_d     = tx_q;
    start_d  = 1'b0;
    err_d    = 1'b0;
    to_d     = 1'b0;
    ovr_d    = 1'b0;
    settle_d = 1'b0;
    case (state_q)
      ST_WAIT_A: if (bus.i_rx_valid) begin
        a_d     = bus.i_rx_data;
        state_d = ST_WAIT_B;
      end
      ST_WAIT_B: if (bus.i_rx_valid) begin
        b_d     = bus.i_rx_data;
        state_d = ST_WAIT_OP;
      end else if (expire) begin
        to_d    = 1'b1;
        state_d = ST_WAIT_A;
      end
      ST_WAIT_OP: if (bus.i_rx_valid) begin
        if (op_valid(bus.i_rx_data[NB_OP-1:0])) begin
          op_d    = bus.i_rx_data[NB_OP-1:0];
          state_d = ST_EXEC;
        end else begin
          err_d   = 1'b1;
          state_d = ST_WAIT_A;
        end
      end else if (expire) begin
        to_d    = 1'b1;
        state_d = ST_WAIT_A;
      end
      // first EXEC cycle lets the ALU settle; the second captures and launches TX
      ST_EXEC: begin
        ovr_d    = bus.i_rx_valid;
        settle_d = !settle_q;
        if (settle_q) begin
          tx_d    = bus.i_alu_result;
          start_d = 1'b1;
          state_d = ST_WAIT_TX;
        end
      end
      ST_WAIT_TX: begin
        ovr_d   = bus.i_rx_valid;
        state_d = bus.i_tx_done ? ST_WAIT_A : ST_WAIT_TX;
      end
      default: state_d = ST_WAIT_A;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state_q  <= ST_WAIT_A;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      tx_q     <= '0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
      ovr_q    <= 1'b0;
      settle_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      tx_q     <= tx_d;
      start_q  <= start_d;
      err_q    <= err_d;
      to_q     <= to_d;
      ovr_q    <= ovr_d;
      settle_q <= settle_d;
    end
  assign bus.o_alu_a    = a_q;
  assign bus.o_alu_b    = b_q;
  assign bus.o_alu_op   = op_q;
  assign bus.o_tx_data  = tx_q;
  assign bus.o_tx_start = start_q;
  assign bus.o_ready    = state_q inside {ST_WAIT_A, ST_WAIT_B, ST_WAIT_OP};
  assign bus.o_op_err   = err_q;
  assign bus.o_timeout  = to_q;
  assign bus.o_overrun  = ovr_q;
endmodule

// File: tb/tb_uart_alu_ctrl.sv
// tb_uart_alu_ctrl: directed frames against a behavioural ALU with hand-computed results.
module tb_uart_alu_ctrl;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  uart_alu_ctrl_if #(.NB_DATA(8)) bus ();
  uart_alu_ctrl #(.NB_DATA(8), .F_CLOCK(5000), .TIMEOUT_CYCLES(50)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] alu_f(input logic [7:0] a, b, input logic [5:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SRA:  return 8'($signed(a) >>> b);
      OP_SRL:  return a >> b;
      default: return 8'h00;
    endcase
  endfunction
  assign bus.i_alu_result = alu_f(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    @(negedge clk);
    bus.i_rx_valid = 1'b0;
  endtask
  task automatic finish_tx(input string tag);
    idle(3);
    chk({tag, " busy"}, bus.o_ready, 0);
    bus.i_tx_done = 1'b1;
    @(negedge clk);
    bus.i_tx_done = 1'b0;
    chk({tag, " ready"}, bus.o_ready, 1);
  endtask
  task automatic send_ops(input logic [7:0] a, b, op);
    send_byte(a);
    idle(2);
    send_byte(b);
    idle(2);
    send_byte(op);
  endtask
  task automatic run_frame(input logic [7:0] a, b, op, exp, input string tag);
    send_ops(a, b, op);
    chk({tag, " start e0"}, bus.o_tx_start, 0);
    chk({tag, " op"}, bus.o_alu_op, op[5:0]);
    idle(1);
    chk({tag, " start e1"}, bus.o_tx_start, 0);
    idle(1);
    chk({tag, " start e2"}, bus.o_tx_start, 1);
    chk({tag, " data"}, bus.o_tx_data, exp);
    idle(1);
    chk({tag, " start pulse"}, bus.o_tx_start, 0);
    chk({tag, " data held"}, bus.o_tx_data, exp);
    finish_tx(tag);
  endtask
  initial begin
    bus.i_rx_data  = 8'h00;
    bus.i_rx_valid = 1'b0;
    bus.i_tx_done  = 1'b0;
    idle(2);
    chk("rst a", bus.o_alu_a, 0);
    chk("rst tx_data", bus.o_tx_data, 0);
    chk("rst start", bus.o_tx_start, 0);
    chk("rst err", bus.o_op_err, 0);
    chk("rst ready", bus.o_ready, 1);
    rst = 1'b0;
    idle(1);
    run_frame(8'h43, 8'h21, 8'h20, 8'h64, "add");
    run_frame(8'h10, 8'h03, 8'h22, 8'h0D, "sub");
    run_frame(8'h80, 8'h01, 8'h03, 8'hC0, "sra");
    run_frame(8'h0F, 8'hF0, 8'hE5, 8'hFF, "or hi bits");
    send_ops(8'h05, 8'h06, 8'h3F);
    chk("inv err", bus.o_op_err, 1);
    chk("inv ready", bus.o_ready, 1);
    chk("inv op kept", bus.o_alu_op, 6'b100101);
    idle(1);
    chk("inv err pulse", bus.o_op_err, 0);
    idle(2);
    chk("inv no start", bus.o_tx_start, 0);
    run_frame(8'h01, 8'h01, 8'h20, 8'h02, "after inv");
    send_byte(8'h11);
    idle(49);
    chk("to early", bus.o_timeout, 0);
    idle(1);
    chk("to pulse", bus.o_timeout, 1);
    chk("to ready", bus.o_ready, 1);
    idle(1);
    chk("to pulse end", bus.o_timeout, 0);
    chk("to no start", bus.o_tx_start, 0);
    run_frame(8'h01, 8'h02, 8'h20, 8'h03, "after to");
    send_byte(8'h11);
    idle(49);
    send_byte(8'h22);
    chk("to edge none", bus.o_timeout, 0);
    chk("to edge b", bus.o_alu_b, 8'h22);
    idle(2);
    send_byte(8'h20);
    idle(2);
    chk("to edge data", bus.o_tx_data, 8'h33);
    finish_tx("to edge");
    send_ops(8'h30, 8'h05, 8'h20);
    idle(2);
    chk("ovr start", bus.o_tx_start, 1);
    send_byte(8'hAA);
    chk("ovr pulse", bus.o_overrun, 1);
    chk("ovr data", bus.o_tx_data, 8'h35);
    chk("ovr a", bus.o_alu_a, 8'h30);
    idle(1);
    chk("ovr pulse end", bus.o_overrun, 0);
    finish_tx("ovr");
    send_byte(8'h77);
    chk("ar a set", bus.o_alu_a, 8'h77);
    #2 rst = 1'b1;
    #1;
    chk("ar mid a", bus.o_alu_a, 0);
    chk("ar mid data", bus.o_tx_data, 0);
    chk("ar mid ready", bus.o_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    send_ops(8'h50, 8'h02, 8'h02);
    idle(3);
    chk("ar tx data", bus.o_tx_data, 8'h14);
    #2 rst = 1'b1;
    #1;
    chk("ar tx data0", bus.o_tx_data, 0);
    chk("ar tx op0", bus.o_alu_op, 0);
    chk("ar tx start0", bus.o_tx_start, 0);
    chk("ar tx ready", bus.o_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    run_frame(8'h09, 8'h04, 8'h22, 8'h05, "after ar");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
